// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits.
// The divisor is latched at frame acceptance; dropping tx_en aborts a frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for tx_en && tx_start
// ST_START | line low for one bit period
// ST_DATA  | line carries shift_q[0]; eight bit periods, LSB first
// ST_STOP  | line high for STOP_BITS bit periods, then done pulse
module uart_tx #(
   parameter int STOP_BITS = 1
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        tx_en,
   input  logic [31:0] baud_div,
   input  logic        tx_start,
   input  logic [7:0]  tx_data_in,
   output logic        tx_serial,
   output logic        tx_busy,
   output logic        tx_done_tick
);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   // index of the last stop bit (only 1 or 2 stop bits are legal)
   localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] div_q, div_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_idx_q, stop_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        serial_q, serial_d;
   logic        done_q, done_d;
   logic        bit_end;

   assign bit_end      = (cnt_q == (div_q - 32'd1));
   assign tx_serial    = serial_q;
   assign tx_busy      = (state_q != ST_IDLE);
   assign tx_done_tick = done_q;

   // next-state, datapath and registered-output values
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      serial_d   = 1'b1;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_en && tx_start) begin
               shift_d  = tx_data_in;
               div_d    = (baud_div == 32'd0) ? 32'd1 : baud_div;
               cnt_d    = 32'd0;
               state_d  = ST_START;
               serial_d = 1'b0;
            end
         end
         ST_START: begin
            serial_d = 1'b0;
            if (bit_end) begin
               cnt_d     = 32'd0;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
               serial_d  = shift_q[0];
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_DATA: begin
            serial_d = shift_q[0];
            if (bit_end) begin
               cnt_d   = 32'd0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  stop_idx_d = 1'b0;
                  state_d    = ST_STOP;
                  serial_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  serial_d  = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_STOP: begin
            serial_d = 1'b1;
            if (bit_end) begin
               cnt_d = 32'd0;
               if (stop_idx_q == STOP_LAST) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // losing the enable mid-frame drops the frame without a done pulse
      if (!tx_en && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         cnt_d    = 32'd0;
         serial_d = 1'b1;
         done_d   = 1'b0;
      end
   end

   // state and datapath registers; reset leaves the line idle high
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 32'd0;
         div_q      <= 32'd1;
         bit_idx_q  <= 3'd0;
         stop_idx_q <= 1'b0;
         shift_q    <= 8'd0;
         serial_q   <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         serial_q   <= serial_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with one stop bit, one with two.
module tb_uart_tx;

   logic        clk;
   logic        arst_n;
   logic        tx_en;
   logic [31:0] baud_div;
   logic        tx_start;
   logic [7:0]  tx_data_in;
   logic        tx_serial;
   logic        tx_busy;
   logic        tx_done_tick;

   logic [31:0] baud_div2;
   logic        tx_start2;
   logic        tx_serial2;
   logic        tx_busy2;
   logic        tx_done_tick2;

   int n_chk  = 0;
   int n_pass = 0;

   uart_tx #(.STOP_BITS(1)) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .tx_en        (tx_en),
      .baud_div     (baud_div),
      .tx_start     (tx_start),
      .tx_data_in   (tx_data_in),
      .tx_serial    (tx_serial),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
   );

   uart_tx #(.STOP_BITS(2)) dut2 (
      .clk          (clk),
      .arst_n       (arst_n),
      .tx_en        (tx_en),
      .baud_div     (baud_div2),
      .tx_start     (tx_start2),
      .tx_data_in   (tx_data_in),
      .tx_serial    (tx_serial2),
      .tx_busy      (tx_busy2),
      .tx_done_tick (tx_done_tick2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept one frame; on return we observe the cycle right after the acceptance edge
   task automatic send(input logic [7:0] d, input logic [31:0] div);
      baud_div   = div;
      tx_data_in = d;
      tx_start   = 1'b1;
      tick();
      tx_start   = 1'b0;
   endtask

   // observe n = 0..maxc after acceptance: bit-centre samples, busy cycles, done pulses
   task automatic capture(input int d, input int maxc, input int pulse_at,
                          output logic [9:0] bits, output int len,
                          output int busy_cnt, output int done_cnt);
      bits = '0; len = -1; busy_cnt = 0; done_cnt = 0;
      for (int n = 0; n <= maxc; n++) begin
         for (int j = 0; j < 10; j++)
            if (n == j * d + d / 2) bits[j] = tx_serial;
         if (tx_busy) busy_cnt++;
         if (tx_done_tick) begin
            done_cnt++;
            if (len < 0) len = n;
         end
         if (pulse_at >= 0 && n == pulse_at) begin
            tx_start   = 1'b1;
            tx_data_in = 8'hFF;
            baud_div   = 32'd3;
         end else if (pulse_at >= 0 && n == pulse_at + 1) begin
            tx_start = 1'b0;
         end
         tick();
      end
   endtask

   task automatic count_done(input int cycles, output int done_cnt, output int busy_cnt);
      done_cnt = 0; busy_cnt = 0;
      for (int n = 0; n < cycles; n++) begin
         if (tx_done_tick) done_cnt++;
         if (tx_busy) busy_cnt++;
         tick();
      end
   endtask

   logic [9:0] bits;
   int len, bcnt, dcnt, hi, len2;

   initial begin
      arst_n = 1'b0; tx_en = 1'b0; baud_div = 32'd16; tx_start = 1'b0;
      tx_data_in = 8'h00; baud_div2 = 32'd4; tx_start2 = 1'b0;
      #12;
      chk("rst_serial", {31'd0, tx_serial}, 32'd1);
      chk("rst_busy",   {31'd0, tx_busy}, 32'd0);
      chk("rst_done",   {31'd0, tx_done_tick}, 32'd0);
      arst_n = 1'b1;
      tick(); tick();

      // start while disabled is ignored
      tx_start = 1'b1;
      tick(); tick(); tick();
      tx_start = 1'b0;
      chk("dis_start_busy", {31'd0, tx_busy}, 32'd0);
      tx_en = 1'b1;
      tick();

      // reset in idle
      #2 arst_n = 1'b0;
      #1;
      chk("rst_idle_serial", {31'd0, tx_serial}, 32'd1);
      chk("rst_idle_busy",   {31'd0, tx_busy}, 32'd0);
      arst_n = 1'b1;
      tick();

      // single frame 0xA5, D=16
      send(8'hA5, 32'd16);
      capture(16, 200, -1, bits, len, bcnt, dcnt);
      chk("a5_bits", {22'd0, bits}, 32'h34A);
      chk("a5_len",  len, 32'd160);
      chk("a5_busy", bcnt, 32'd160);
      chk("a5_done", dcnt, 32'd1);

      // busy rejection with data and divisor changed mid-frame
      send(8'h5A, 32'd16);
      capture(16, 200, 50, bits, len, bcnt, dcnt);
      chk("rej_bits", {22'd0, bits}, 32'h2B4);
      chk("rej_len",  len, 32'd160);
      chk("rej_busy", bcnt, 32'd160);
      chk("rej_done", dcnt, 32'd1);
      baud_div = 32'd16;

      // abort in data bit 3 (observations 64..79)
      send(8'hA5, 32'd16);
      for (int n = 0; n < 70; n++) tick();
      chk("abort_pre_serial", {31'd0, tx_serial}, 32'd0);
      tx_en = 1'b0;
      tick();
      chk("abort_serial", {31'd0, tx_serial}, 32'd1);
      chk("abort_busy",   {31'd0, tx_busy}, 32'd0);
      chk("abort_nodone", {31'd0, tx_done_tick}, 32'd0);
      tx_en = 1'b1;
      count_done(30, dcnt, bcnt);
      chk("abort_done_cnt", dcnt, 32'd0);
      send(8'hC3, 32'd16);
      capture(16, 180, -1, bits, len, bcnt, dcnt);
      chk("post_abort_bits", {22'd0, bits}, 32'h386);
      chk("post_abort_len",  len, 32'd160);

      // back-to-back with baud_div = 0 (treated as 1)
      baud_div = 32'd0; tx_data_in = 8'h00; tx_start = 1'b1;
      tick();
      capture(1, 32, -1, bits, len, bcnt, dcnt);
      chk("b2b_bits", {22'd0, bits}, 32'h200);
      chk("b2b_len",  len, 32'd10);
      chk("b2b_busy", bcnt, 32'd30);
      chk("b2b_done", dcnt, 32'd3);
      tx_start = 1'b0;
      count_done(20, dcnt, bcnt);

      // two stop bits, D=4: 44-cycle frame, 8 stop cycles (data 0x00)
      tx_data_in = 8'h00; baud_div2 = 32'd4; tx_start2 = 1'b1;
      tick();
      tx_start2 = 1'b0;
      len2 = -1; hi = 0;
      for (int n = 0; n <= 60; n++) begin
         if (tx_busy2 && tx_serial2) hi++;
         if (tx_done_tick2 && len2 < 0) len2 = n;
         tick();
      end
      chk("stop2_len", len2, 32'd44);
      chk("stop2_hi",  hi, 32'd8);

      // reset mid-DATA (observation 40 is data bit 1 of 0xA5, a 0)
      baud_div = 32'd16;
      send(8'hA5, 32'd16);
      for (int n = 0; n < 40; n++) tick();
      chk("rstd_pre_serial", {31'd0, tx_serial}, 32'd0);
      #2 arst_n = 1'b0;
      #1;
      chk("rstd_serial", {31'd0, tx_serial}, 32'd1);
      chk("rstd_busy",   {31'd0, tx_busy}, 32'd0);
      chk("rstd_done",   {31'd0, tx_done_tick}, 32'd0);
      #2 arst_n = 1'b1;
      tick();
      count_done(200, dcnt, bcnt);
      chk("rstd_no_done", dcnt, 32'd0);
      chk("rstd_no_busy", bcnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
